e1_tx_sequencer: RTL
====================

Name: e1_tx_sequencer

Overview:
Transmit-side E1 (G.704) frame sequencer.
- Walks bit, timeslot (TS0-31) and frame (0-15) counters.
- Places the alignment byte in TS0 (FAS on even frames, NFAS on odd frames).
- Pulls payload bytes for the other timeslots from the tributary through a valid/ready handshake.
- Presents one byte per slot to the downstream serializer.
- Sits between the tributary buffer and the line serializer, clocked with a bit-rate enable.

Parameters:
- FAS_BYTE, 8'h1B, TS0 content on even frames.
- NFAS_BASE, 8'h5F, TS0 content on odd frames before Si/A overrides.
- IDLE_BYTE, 8'hFF, substituted byte on payload underflow and while idle.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- bit_en  in  1  one-cycle strobe per E1 bit period (2.048 MHz)
- en  in  1  run request
- rai  in  1  remote alarm; drives the NFAS A-bit
- pl_data  in  8  tributary payload byte
- pl_valid  in  1  pl_data is valid
- pl_ready  out  1  payload byte consumed this cycle
- sig_data  in  8  TS16 signalling byte (used only with the optional feature)
- sig_valid  in  1  sig_data is valid
- sig_ready  out  1  signalling byte consumed this cycle
- tx_byte  out  8  byte for the upcoming slot
- tx_byte_valid  out  1  one-cycle strobe; tx_byte has been updated
- ts_num  out  5  slot index of tx_byte
- frame_num  out  4  frame index of tx_byte
- mf_start  out  1  high with tx_byte_valid when frame_num=0 and ts_num=0
- underflow  out  1  one-cycle pulse when IDLE_BYTE is substituted for payload

Behaviour:
- Reset values: tx_byte=IDLE_BYTE; all other outputs and all counters = 0; state=IDLE.
- States:
  - IDLE: counters held at 0. Transition to RUN on the first cycle with en=1 and bit_en=1.
  - RUN: bit_cnt (0-7) advances on each bit_en.
- Slot boundaries ("boundary cycle"):
  - the IDLE->RUN transition cycle;
  - any RUN cycle with bit_en=1 and bit_cnt=7.
- At each boundary the next slot (f,t) is selected:
  - t = ts+1 mod 32.
  - f advances mod 16 when t wraps to 0.
  - The IDLE->RUN boundary selects (0,0).
- Byte selection, registered: tx_byte, ts_num, frame_num, tx_byte_valid and mf_start update exactly 1 cycle after the boundary cycle.
  - TS0, f even: FAS_BYTE.
  - TS0, f odd: NFAS_BASE with bit7 (Si) = 1 for f in {5,9,11}, else 0, and bit5 (A) = rai sampled at the boundary cycle. Result: 0x5F/0xDF, or 0x7F/0xFF with rai=1.
  - Other slots: payload.
- Payload handshake:
  - pl_ready is combinational and high only in a boundary cycle whose next slot is payload.
  - Transfer = pl_ready & pl_valid, which loads pl_data.
  - If pl_valid=0 in that cycle, tx_byte=IDLE_BYTE and underflow pulses in the same cycle as tx_byte_valid.
  - No lookahead: pl_valid outside boundary cycles is ignored.
- Stopping:
  - en deassert in RUN: the current frame completes through TS31.
  - On the boundary that would select TS0 of the next frame, go to IDLE instead, with tx_byte_valid=0, tx_byte=IDLE_BYTE and counters zeroed.
  - en reasserting before that boundary cancels the stop.
- bit_en in non-boundary cycles changes only bit_cnt. bit_en=0 freezes everything.
- rst has priority over all inputs in the same cycle. Mid-frame reset returns immediately to IDLE and reset values; no partial frame completes.

Optional Feature:
- SIG_TS16_EN defined (TS16 carries CAS signalling):
  - frame 0 TS16 = 8'h0B (MFAS 0000_1011), with no handshake;
  - frames 1-15 TS16 use the sig_ready/sig_valid handshake under the same timing rules as payload, with IDLE_BYTE plus an underflow pulse on miss;
  - pl_ready is never asserted for TS16.
- Not defined:
  - TS16 is ordinary payload;
  - sig_ready is tied to 0 and sig_data/sig_valid are ignored.

Decomposition:
- Shared package e1_pkg:
  - FAS/NFAS/MFAS/IDLE constants;
  - NUM_TS=32, NUM_FRAMES=16;
  - Si-bit frame mask 16'h0A20 (bits 5,9,11);
  - state enum {IDLE, RUN}.
- One natural sub-module: e1_slot_counter (bit/ts/frame counters with boundary and wrap flags). The byte mux and handshake stay in the top.

Test Plan:
1. Reset, en=1, bit_en every 4th clk, pl_valid=1, pl_data=ts index -> TS0 bytes over frames 0-15 are 1B,5F,1B,5F,1B,DF,1B,5F,1B,DF,1B,DF,1B,5F,1B,5F; TS n carries n; tx_byte_valid spacing is 32 clk; mf_start once per 512 bytes.
2. rai=1 during odd frames -> NFAS bytes are 7F or FF (FF in frames 5,9,11); FAS is unchanged at 1B.
3. pl_valid=0 at the TS7 boundary of frame 2 -> tx_byte=FF, underflow=1 for one cycle; TS8 resumes normal payload; no byte is consumed.
4. Drop en at frame 3 TS10 -> TS11-TS31 are still emitted; no TS0 of frame 4; back in IDLE with tx_byte=FF. Re-raise en -> restarts at frame 0 TS0 with 1B.
5. Assert rst at frame 6 TS20 bit 3 -> next cycle all outputs are at reset values; no further tx_byte_valid until en/bit_en restart.
6. With SIG_TS16_EN: frame 0 TS16=0B; frame 1 TS16 from sig_data=A5, with sig_ready pulsed and pl_ready low. Without the macro: TS16 is a payload byte and sig_ready stays 0.

Source files
------------

// File: rtl/e1_pkg.sv
// Shared constants and types for the E1 transmit frame sequencer.
// Holds the TS0/TS16 byte values, frame geometry, the Si frame mask and the FSM state type.
package e1_pkg;

    localparam logic [7:0] E1_FAS  = 8'h1B;
    localparam logic [7:0] E1_NFAS = 8'h5F;
    localparam logic [7:0] E1_MFAS = 8'h0B;
    localparam logic [7:0] E1_IDLE = 8'hFF;

    localparam int NUM_TS     = 32;
    localparam int NUM_FRAMES = 16;

    // Frames whose NFAS byte carries Si = 1 (frames 5, 9 and 11).
    localparam logic [15:0] SI_MASK = 16'h0A20;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [3:0] frame;
        logic [4:0] ts;
    } slot_t;

    // NFAS byte: bit7 is the Si bit and bit5 is the remote-alarm A bit.
    function automatic logic [7:0] nfas_byte(
        input logic [7:0] base,
        input logic [3:0] f,
        input logic       a
    );
        return base | {SI_MASK[f], 1'b0, a, 5'b0};
    endfunction

endpackage

// File: rtl/e1_slot_counter.sv
// Bit / timeslot / frame counters of the E1 transmit sequencer.
// Ports: clk, rst (sync, active-high), bit_en, start (IDLE->RUN), run, clr (stop at frame end);
//        boundary, frame_end (boundary leaving TS31), nxt (slot selected at this boundary).
module e1_slot_counter
    import e1_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  bit_en,
    input  logic  start,
    input  logic  run,
    input  logic  clr,
    output logic  boundary,
    output logic  frame_end,
    output slot_t nxt
);

    logic [2:0] bit_cnt;
    logic [4:0] ts;
    logic [3:0] frame;
    logic       last_bit;
    logic       run_bnd;

    assign last_bit  = (bit_cnt == 3'd7);
    assign run_bnd   = run & bit_en & last_bit;
    assign boundary  = start | run_bnd;
    assign frame_end = run_bnd & (ts == 5'(NUM_TS - 1));

    // Counter widths match NUM_TS/NUM_FRAMES exactly, so the mod wraps are free.
    always_comb begin
        nxt.ts    = ts + 5'd1;
        nxt.frame = (ts == 5'(NUM_TS - 1)) ? frame + 4'd1 : frame;
        if (start) begin
            nxt.ts    = '0;
            nxt.frame = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr || !run) begin
            bit_cnt <= '0;
            ts      <= '0;
            frame   <= '0;
        end else if (bit_en) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (last_bit) begin
                ts    <= nxt.ts;
                frame <= nxt.frame;
            end
        end
    end

endmodule

// File: rtl/e1_tx_sequencer.sv
// E1 (G.704) transmit frame sequencer: builds TS0 alignment bytes and pulls payload per slot.
// Ports: clk, rst (sync, active-high), bit_en, en, rai; pl_data/pl_valid/pl_ready payload
//        handshake; sig_data/sig_valid/sig_ready TS16 handshake; tx_byte, tx_byte_valid,
//        ts_num, frame_num, mf_start, underflow toward the serializer.
// Build option: define SIG_TS16_EN to carry MFAS/CAS signalling in TS16.
module e1_tx_sequencer
    import e1_pkg::*;
#(
    parameter logic [7:0] FAS_BYTE  = E1_FAS,
    parameter logic [7:0] NFAS_BASE = E1_NFAS,
    parameter logic [7:0] IDLE_BYTE = E1_IDLE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_en,
    input  logic       en,
    input  logic       rai,
    input  logic [7:0] pl_data,
    input  logic       pl_valid,
    output logic       pl_ready,
    input  logic [7:0] sig_data,
    input  logic       sig_valid,
    output logic       sig_ready,
    output logic [7:0] tx_byte,
    output logic       tx_byte_valid,
    output logic [4:0] ts_num,
    output logic [3:0] frame_num,
    output logic       mf_start,
    output logic       underflow
);

    state_t     state;
    logic       start;
    logic       stop;
    logic       boundary;
    logic       frame_end;
    slot_t      nxt;
    logic       is_ts0;
    logic       is_mfas;
    logic       is_cas;
    logic [7:0] nxt_byte;
    logic       nxt_uf;

    assign start = (state == IDLE) & en & bit_en;
    // With en low, the boundary leaving TS31 ends the run instead of opening a frame.
    assign stop  = frame_end & ~en;

    e1_slot_counter u_cnt (
        .clk       (clk),
        .rst       (rst),
        .bit_en    (bit_en),
        .start     (start),
        .run       (state == RUN),
        .clr       (stop),
        .boundary  (boundary),
        .frame_end (frame_end),
        .nxt       (nxt)
    );

    assign is_ts0 = (nxt.ts == 5'd0);

`ifdef SIG_TS16_EN
    assign is_mfas   = (nxt.ts == 5'd16) & (nxt.frame == 4'd0);
    assign is_cas    = (nxt.ts == 5'd16) & (nxt.frame != 4'd0);
    assign sig_ready = boundary & ~rst & is_cas;
`else
    logic sig_unused;
    assign sig_unused = ^{sig_data, sig_valid};
    assign is_mfas    = 1'b0;
    assign is_cas     = 1'b0;
    assign sig_ready  = 1'b0;
`endif

    assign pl_ready = boundary & ~rst & ~stop & ~is_ts0 & ~is_mfas & ~is_cas;

    always_comb begin
        nxt_byte = IDLE_BYTE;
        nxt_uf   = 1'b0;
        unique case (1'b1)
            is_ts0: begin
                nxt_byte = nxt.frame[0] ? nfas_byte(NFAS_BASE, nxt.frame, rai)
                                        : FAS_BYTE;
            end
            is_mfas: begin
                nxt_byte = E1_MFAS;
            end
            is_cas: begin
                nxt_byte = sig_valid ? sig_data : IDLE_BYTE;
                nxt_uf   = ~sig_valid;
            end
            default: begin
                nxt_byte = pl_valid ? pl_data : IDLE_BYTE;
                nxt_uf   = ~pl_valid;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            tx_byte       <= IDLE_BYTE;
            tx_byte_valid <= 1'b0;
            ts_num        <= '0;
            frame_num     <= '0;
            mf_start      <= 1'b0;
            underflow     <= 1'b0;
        end else begin
            tx_byte_valid <= 1'b0;
            mf_start      <= 1'b0;
            underflow     <= 1'b0;
            if (stop) begin
                state     <= IDLE;
                tx_byte   <= IDLE_BYTE;
                ts_num    <= '0;
                frame_num <= '0;
            end else if (boundary) begin
                state         <= RUN;
                tx_byte       <= nxt_byte;
                ts_num        <= nxt.ts;
                frame_num     <= nxt.frame;
                tx_byte_valid <= 1'b1;
                mf_start      <= is_ts0 & (nxt.frame == 4'd0);
                underflow     <= nxt_uf;
            end
        end
    end

endmodule
